mac_dot_ctrl: RTL and testbench
===============================

Name: mac_dot_ctrl

Overview:
Sequencer for the SIMD MAC datapath. Computes one long dot product of len_in operand chunks, each SIMD_WIDTH pairs wide, as a single job. It gates the operand stream into the MAC, tracks the MAC's fixed pipeline latency with a valid shift register, and accumulates each per-chunk MAC result into a wide accumulator. It then presents the final sum on a valid/ready result port. It sits between the operand fetch stream and the MAC, and directly above the MAC instance.

Parameters:
MAC_WIDTH, 38, width of the MAC result (mac_out_in), two's complement.
ACC_WIDTH, 48, width of the job accumulator and res_out; must be >= MAC_WIDTH.
MAC_LATENCY, 6, cycles from MAC input_valid to the corresponding result on mac_out_in; must be >= 1.
LEN_WIDTH, 16, width of the chunk-count field.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_in  input  1  reset; synchronous, active-high.
start_in  input  1  job start request; sampled only in IDLE.
len_in  input  LEN_WIDTH  number of chunks in the job; captured with start_in.
busy_out  output  1  high in every state except IDLE.
opd_valid_in  input  1  an operand chunk is present on the MAC a/b buses.
opd_ready_out  output  1  controller accepts the current chunk.
mac_valid_out  output  1  drives MAC input_valid; equals opd_valid_in && opd_ready_out.
mac_out_in  input  MAC_WIDTH  MAC result, signed.
res_valid_out  output  1  res_out holds a completed job result.
res_ready_in  input  1  consumer accepts the result.
res_out  output  ACC_WIDTH  dot-product result, signed.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - state goes to IDLE; all counters, the valid shift register and the accumulator clear to 0.
  - busy_out, opd_ready_out, mac_valid_out and res_valid_out are 0; res_out is 0.
  - Reset overrides every other input, including mid-job; an aborted job produces no result.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE:
  - start_in=1 captures len_in into len_q and clears issue_cnt, pend_cnt and acc.
  - len_in != 0 -> next state FEED.
  - len_in = 0 -> next state DONE with res_out = 0.
- FEED:
  - opd_ready_out = 1 while issue_cnt < len_q.
  - Each handshake (opd_valid_in && opd_ready_out) pulses mac_valid_out, increments issue_cnt and pushes a 1 into the MAC_LATENCY-deep valid shift register; a cycle without a handshake pushes a 0.
  - Once the last chunk is accepted (issue_cnt reaches len_q), next state is DRAIN; opd_ready_out is 0 from that cycle on.
- Accumulate: in any state, when the shift-register output bit is 1, acc <= acc + sign_extend(mac_out_in) and pend_cnt increments. Addition wraps modulo 2^ACC_WIDTH. Chunk results are added in issue order.
- DRAIN:
  - opd_ready_out = 0.
  - When pend_cnt equals len_q after the current accumulate, next state is DONE.
  - Minimum job latency: last handshake to res_valid_out = MAC_LATENCY + 1 cycles.
- DONE:
  - res_valid_out = 1 and res_out = acc, both held stable until res_ready_in = 1.
  - On the handshake, next state is IDLE and res_valid_out drops the following cycle.
  - start_in is ignored in DONE; a start asserted in the same cycle as the handshake is ignored. The next job is accepted one cycle after returning to IDLE.
- start_in is ignored in FEED, DRAIN and DONE; len_in is not re-sampled while busy.
- Stalls: opd_valid_in=0 in FEED inserts bubbles, which propagate as 0 bits in the shift register. Results of already-issued chunks keep draining during stalls.
- No output-side backpressure into the MAC: at most one job is ever in flight, so accumulation never stalls.

Test Plan:
- Basic job: len=3; chunk results 5, -2, 100 appear MAC_LATENCY=6 cycles after each handshake -> res_out=103; res_valid_out rises 7 cycles after the last handshake.
- Bubbles: len=4 with opd_valid_in low on alternate cycles; results 1, 2, 3, 4 -> exactly 4 mac_valid_out pulses, res_out=10, opd_ready_out=0 after the 4th handshake.
- Zero length: start with len=0 -> DONE the next cycle with res_out=0; mac_valid_out never pulses.
- Backpressure and ignored start: hold res_ready_in=0 for 10 cycles with start_in=1 throughout -> res_out stable, no new job starts; release -> IDLE, then a new start is accepted.
- Wrap-around: ACC_WIDTH=48; two chunks each returning 2^37-1, after preloading acc near 2^47 via a len=2^10 job of max-positive results -> res_out equals the modulo-2^48 two's complement sum.
- Reset mid-job: rst_in=1 in DRAIN with 2 results pending -> next cycle all outputs 0 and state IDLE; the late MAC results are not accumulated; a fresh len=1 job returning 7 gives res_out=7.

Source files
------------

// File: rtl/mac_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mac_dot_ctrl
// Description : Job sequencer for the SIMD MAC datapath. Gates the operand
//               stream into the MAC, tracks the MAC pipeline with a valid
//               shift register, accumulates per-chunk results into a wide
//               accumulator and presents the job sum on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_dot_ctrl #(
  parameter int MAC_WIDTH   = 38,
  parameter int ACC_WIDTH   = 48,
  parameter int MAC_LATENCY = 6,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic [LEN_WIDTH-1:0] len_in,
  output logic                 busy_out,
  input  logic                 opd_valid_in,
  output logic                 opd_ready_out,
  output logic                 mac_valid_out,
  input  logic [MAC_WIDTH-1:0] mac_out_in,
  output logic                 res_valid_out,
  input  logic                 res_ready_in,
  output logic [ACC_WIDTH-1:0] res_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]   pend_cnt_q, pend_cnt_d;
  logic [MAC_LATENCY-1:0] vsr_q, vsr_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;

  logic                   hs;
  logic                   acc_en;
  logic [ACC_WIDTH-1:0]   mac_ext;

  // Operand gating: chunks are only accepted in FEED until len_q have issued.
  assign opd_ready_out = (state_q == S_FEED) && (issue_cnt_q < len_q);
  assign hs            = opd_valid_in && opd_ready_out;
  assign mac_valid_out = hs;

  assign busy_out      = (state_q != S_IDLE);
  assign res_valid_out = (state_q == S_DONE);
  assign res_out       = res_valid_out ? acc_q : '0;

  // The oldest valid-shift-register bit marks the cycle a MAC result lands.
  assign acc_en  = vsr_q[MAC_LATENCY-1];
  assign mac_ext = ACC_WIDTH'(signed'(mac_out_in));

  generate
    if (MAC_LATENCY == 1) begin : g_vsr_single
      assign vsr_d = hs;
    end else begin : g_vsr_multi
      assign vsr_d = {vsr_q[MAC_LATENCY-2:0], hs};
    end
  endgenerate

  // Next-state, counter and accumulator logic.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pend_cnt_d  = pend_cnt_q;
    acc_d       = acc_q;

    if (acc_en) begin
      acc_d      = acc_q + mac_ext;
      pend_cnt_d = pend_cnt_q + LEN_WIDTH'(1);
    end
    if (hs) begin
      issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          len_d       = len_in;
          issue_cnt_d = '0;
          pend_cnt_d  = '0;
          acc_d       = '0;
          state_d     = (len_in == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (issue_cnt_d == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pend_cnt_d == len_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pend_cnt_q  <= '0;
      vsr_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pend_cnt_q  <= pend_cnt_d;
      vsr_q       <= vsr_d;
      acc_q       <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mac_dot_ctrl
// Description : Self-checking bench for mac_dot_ctrl with a behavioural MAC
//               delay line, table-driven jobs and hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_dot_ctrl;

  localparam int MAC_W   = 38;
  localparam int ACC_W   = 48;
  localparam int MAC_LAT = 6;
  localparam int LEN_W   = 16;
  localparam logic [MAC_W-1:0] GARBAGE = 38'h15_A5A5_A5A5;

  logic             clk = 1'b0;
  logic             rst_in = 1'b1;
  logic             start_in = 1'b0;
  logic [LEN_W-1:0] len_in = '0;
  logic             busy_out;
  logic             opd_valid_in = 1'b0;
  logic             opd_ready_out;
  logic             mac_valid_out;
  logic [MAC_W-1:0] mac_out_in;
  logic             res_valid_out;
  logic             res_ready_in = 1'b0;
  logic [ACC_W-1:0] res_out;

  int checks   = 0;
  int failures = 0;

  mac_dot_ctrl #(
    .MAC_WIDTH  (MAC_W),
    .ACC_WIDTH  (ACC_W),
    .MAC_LATENCY(MAC_LAT),
    .LEN_WIDTH  (LEN_W)
  ) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .len_in       (len_in),
    .busy_out     (busy_out),
    .opd_valid_in (opd_valid_in),
    .opd_ready_out(opd_ready_out),
    .mac_valid_out(mac_valid_out),
    .mac_out_in   (mac_out_in),
    .res_valid_out(res_valid_out),
    .res_ready_in (res_ready_in),
    .res_out      (res_out)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: each accepted chunk pops its result from a queue and
  // emerges MAC_LAT cycles later; idle slots carry a junk pattern.
  logic [MAC_W-1:0] mac_q [$];
  logic [MAC_W-1:0] dl [MAC_LAT];

  initial begin
    for (int i = 0; i < MAC_LAT; i++) dl[i] = GARBAGE;
  end

  always @(posedge clk) begin
    logic [MAC_W-1:0] nv;
    nv = GARBAGE;
    if (mac_valid_out && (mac_q.size() > 0)) nv = mac_q.pop_front();
    for (int i = MAC_LAT - 1; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= nv;
  end

  assign mac_out_in = dl[MAC_LAT-1];

  typedef struct {
    int                      len;
    bit                      bubble;
    logic [3:0][MAC_W-1:0]   v;
    logic [ACC_W-1:0]        exp_res;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int len, input bit bub, input int a, input int b,
                              input int c, input int d, input longint e);
    vec_t t;
    t.len     = len;
    t.bubble  = bub;
    t.v[0]    = MAC_W'(a);
    t.v[1]    = MAC_W'(b);
    t.v[2]    = MAC_W'(c);
    t.v[3]    = MAC_W'(d);
    t.exp_res = ACC_W'(e);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input vec_t t);
    for (int i = 0; i < t.len && i < 4; i++) mac_q.push_back(t.v[i]);
  endtask

  // Runs one job from IDLE to DONE; checks pulse count, result, latency and
  // the ready drop after the final chunk. Optionally leaves the result held.
  task automatic run_job(input string id, input vec_t t, input bit hold);
    int  cyc;
    int  last_hs;
    int  pulses;
    bit  ready_bad;
    int  bound;
    bound     = t.len * 3 + 40;
    cyc       = 0;
    last_hs   = -1;
    pulses    = 0;
    ready_bad = 1'b0;

    chk({id, "_idle_before"}, 64'(busy_out), 64'd0);
    start_in = 1'b1;
    len_in   = LEN_W'(t.len);
    step();
    start_in = 1'b0;
    chk({id, "_busy"}, 64'(busy_out), 64'd1);

    while (!res_valid_out && cyc < bound) begin
      opd_valid_in = t.bubble ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (pulses >= t.len && opd_ready_out) ready_bad = 1'b1;
      if (mac_valid_out) begin
        pulses++;
        last_hs = cyc;
      end
      step();
      cyc++;
    end
    opd_valid_in = 1'b0;

    chk({id, "_res_valid_reached"}, 64'(res_valid_out), 64'd1);
    chk({id, "_mac_pulses"}, 64'(pulses), 64'(t.len));
    chk({id, "_res_out"}, 64'(res_out), 64'(t.exp_res));
    chk({id, "_ready_after_last"}, 64'(ready_bad), 64'd0);
    if (t.len == 0) begin
      chk({id, "_zero_len_cycles"}, 64'(cyc), 64'd0);
    end else if (!t.bubble) begin
      chk({id, "_latency"}, 64'(cyc - last_hs), 64'(MAC_LAT + 1));
    end

    if (!hold) begin
      res_ready_in = 1'b1;
      step();
      res_ready_in = 1'b0;
      chk({id, "_res_valid_drop"}, 64'(res_valid_out), 64'd0);
      chk({id, "_idle_after"}, 64'(busy_out), 64'd0);
    end
  endtask

  initial begin
    vec_t wrap_v;

    tbl[0] = mk(3, 1'b0, 5, -2, 100, 0, 103);
    tbl[1] = mk(4, 1'b1, 1, 2, 3, 4, 10);
    tbl[2] = mk(0, 1'b0, 0, 0, 0, 0, 0);
    tbl[3] = mk(2, 1'b0, -100, 40, 0, 0, -60);
    tbl[4] = mk(1, 1'b0, -7, 0, 0, 0, -7);

    // Reset with start and operand valid asserted: reset must win.
    rst_in       = 1'b1;
    start_in     = 1'b1;
    len_in       = 16'd5;
    opd_valid_in = 1'b1;
    repeat (3) step();
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_opd_ready", 64'(opd_ready_out), 64'd0);
    chk("rst_mac_valid", 64'(mac_valid_out), 64'd0);
    chk("rst_res_valid", 64'(res_valid_out), 64'd0);
    chk("rst_res_out", 64'(res_out), 64'd0);
    start_in     = 1'b0;
    opd_valid_in = 1'b0;
    rst_in       = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      push_vec(tbl[i]);
      run_job($sformatf("job%0d", i), tbl[i], 1'b0);
      step();
    end

    // Backpressure with start held high: result stays put, no new job.
    mac_q.push_back(MAC_W'(9));
    run_job("bp", mk(1, 1'b0, 9, 0, 0, 0, 9), 1'b1);
    start_in = 1'b1;
    len_in   = 16'd5;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold_valid%0d", i), 64'(res_valid_out), 64'd1);
      chk($sformatf("bp_hold_res%0d", i), 64'(res_out), 64'd9);
    end
    res_ready_in = 1'b1;
    step();
    res_ready_in = 1'b0;
    chk("bp_start_ignored_on_hs", 64'(busy_out), 64'd0);
    start_in = 1'b0;
    mac_q.push_back(MAC_W'(11));
    run_job("bp_next", mk(1, 1'b0, 11, 0, 0, 0, 11), 1'b0);
    step();

    // Wrap-around: 1026 max-positive chunks overflow the signed 48-bit range.
    wrap_v         = mk(1026, 1'b0, 0, 0, 0, 0, 0);
    wrap_v.exp_res = 48'h803F_FFFF_FBFE;
    for (int i = 0; i < 1026; i++) mac_q.push_back(38'h1F_FFFF_FFFF);
    run_job("wrap", wrap_v, 1'b0);
    step();

    // Reset in DRAIN with two results still in the MAC pipe.
    mac_q.push_back(MAC_W'(1));
    mac_q.push_back(MAC_W'(2));
    mac_q.push_back(MAC_W'(3));
    start_in = 1'b1;
    len_in   = 16'd3;
    step();
    start_in = 1'b0;
    for (int c = 0; c < 7; c++) begin
      opd_valid_in = 1'b1;
      step();
    end
    opd_valid_in = 1'b0;
    #1;
    chk("mid_in_drain_busy", 64'(busy_out), 64'd1);
    chk("mid_in_drain_ready", 64'(opd_ready_out), 64'd0);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("mid_rst_busy", 64'(busy_out), 64'd0);
    chk("mid_rst_opd_ready", 64'(opd_ready_out), 64'd0);
    chk("mid_rst_mac_valid", 64'(mac_valid_out), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid_out), 64'd0);
    chk("mid_rst_res_out", 64'(res_out), 64'd0);
    mac_q.delete();
    mac_q.push_back(MAC_W'(7));
    run_job("after_rst", mk(1, 1'b0, 7, 0, 0, 0, 7), 1'b0);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
